// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters with registered, counter-aligned hs/vs/blank.
// Define VGA_FRAME_TICK_EN to add the one-cycle frame_tick output at the last pixel of a frame.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        clk_25MHz,
    input  logic        reset_n,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hs,
    output logic        vs,
    output logic        blank
`ifdef VGA_FRAME_TICK_EN
   ,output logic        frame_tick
`endif
);

    localparam logic [10:0] H_TOTAL   = 11'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
    localparam logic [10:0] V_TOTAL   = 11'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
    localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] H_LAST    = H_TOTAL - 11'd1;
    localparam logic [10:0] V_LAST    = V_TOTAL - 11'd1;

    logic        h_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        hs_next;
    logic        vs_next;
    logic        blank_next;

    // Decode from the next counter values so the registered flags line up
    // with the counters they describe.
    always_comb begin
        h_wrap     = (hcount == H_LAST);
        h_next     = h_wrap ? 11'd0 : hcount + 11'd1;
        v_next     = vcount;
        if (h_wrap) begin
            v_next = (vcount == V_LAST) ? 11'd0 : vcount + 11'd1;
        end
        hs_next    = !((h_next >= HS_START) && (h_next < HS_END));
        vs_next    = !((v_next >= VS_START) && (v_next < VS_END));
        blank_next = (h_next >= H_VIS) || (v_next >= V_VIS);
    end

    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= 11'd0;
            vcount <= 11'd0;
            hs     <= 1'b1;
            vs     <= 1'b1;
            blank  <= 1'b0;
        end else begin
            hcount <= h_next;
            vcount <= v_next;
            hs     <= hs_next;
            vs     <= vs_next;
            blank  <= blank_next;
        end
    end

`ifdef VGA_FRAME_TICK_EN
    always_ff @(posedge clk_25MHz or negedge reset_n) begin
        if (!reset_n) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (h_next == H_LAST) && (v_next == V_LAST);
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a reduced-geometry instance covers whole frames, a default
// instance covers the first lines; both are checked every cycle against a model.
module tb_vga_timing_gen;

    // reduced geometry: 30 clocks per line, 19 lines per frame
    localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 4;
    localparam int S_VV = 12, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int D_HV = 640, D_HF = 16, D_HS = 96, D_HB = 48;
    localparam int D_VV = 480, D_VF = 10, D_VS = 2, D_VB = 33;

    typedef struct {
        int h;
        int v;
        int hs;
        int vs;
        int blank;
        int tick;
    } exp_t;

    logic        clk_25MHz;
    logic        reset_n;
    logic [10:0] s_hcount, s_vcount, d_hcount, d_vcount;
    logic        s_hs, s_vs, s_blank, d_hs, d_vs, d_blank;
    logic        s_tick, d_tick;

    int checks = 0;
    int errors = 0;
    exp_t sb_s[$];
    exp_t sb_d[$];
    int sh, sv, dh, dv;
    int s_ticks = 0;

    vga_timing_gen #(
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) u_small (
        .clk_25MHz (clk_25MHz),
        .reset_n   (reset_n),
        .hcount    (s_hcount),
        .vcount    (s_vcount),
        .hs        (s_hs),
        .vs        (s_vs),
        .blank     (s_blank)
`ifdef VGA_FRAME_TICK_EN
       ,.frame_tick(s_tick)
`endif
    );

    vga_timing_gen u_dflt (
        .clk_25MHz (clk_25MHz),
        .reset_n   (reset_n),
        .hcount    (d_hcount),
        .vcount    (d_vcount),
        .hs        (d_hs),
        .vs        (d_vs),
        .blank     (d_blank)
`ifdef VGA_FRAME_TICK_EN
       ,.frame_tick(d_tick)
`endif
    );

`ifndef VGA_FRAME_TICK_EN
    assign s_tick = 1'b0;
    assign d_tick = 1'b0;
`endif

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        if (obs != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic exp_t model(input int h, input int v, input int hv, input int hf,
                                   input int hsy, input int hb, input int vv, input int vf,
                                   input int vsy, input int vb, input int in_reset);
        exp_t e;
        e.h     = h;
        e.v     = v;
        e.hs    = (h >= hv + hf && h < hv + hf + hsy) ? 0 : 1;
        e.vs    = (v >= vv + vf && v < vv + vf + vsy) ? 0 : 1;
        e.blank = (h >= hv || v >= vv) ? 1 : 0;
        e.tick  = (h == hv + hf + hsy + hb - 1 && v == vv + vf + vsy + vb - 1) ? 1 : 0;
        if (in_reset != 0) begin
            e.hs = 1; e.vs = 1; e.blank = 0; e.tick = 0;
        end
        return e;
    endfunction

    task automatic push_expected(input int in_reset);
        sb_s.push_back(model(sh, sv, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, in_reset));
        sb_d.push_back(model(dh, dv, D_HV, D_HF, D_HS, D_HB, D_VV, D_VF, D_VS, D_VB, in_reset));
    endtask

    task automatic compare_outputs(input string pfx);
        exp_t e;
        if (sb_s.size() == 0 || sb_d.size() == 0) begin
            chk({pfx, " scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb_s.pop_front();
        chk({pfx, " s_hcount"}, int'(s_hcount), e.h);
        chk({pfx, " s_vcount"}, int'(s_vcount), e.v);
        chk({pfx, " s_hs"},     int'(s_hs),     e.hs);
        chk({pfx, " s_vs"},     int'(s_vs),     e.vs);
        chk({pfx, " s_blank"},  int'(s_blank),  e.blank);
`ifdef VGA_FRAME_TICK_EN
        chk({pfx, " s_tick"},   int'(s_tick),   e.tick);
        if (s_tick) s_ticks++;
`endif
        e = sb_d.pop_front();
        chk({pfx, " d_hcount"}, int'(d_hcount), e.h);
        chk({pfx, " d_vcount"}, int'(d_vcount), e.v);
        chk({pfx, " d_hs"},     int'(d_hs),     e.hs);
        chk({pfx, " d_vs"},     int'(d_vs),     e.vs);
        chk({pfx, " d_blank"},  int'(d_blank),  e.blank);
`ifdef VGA_FRAME_TICK_EN
        chk({pfx, " d_tick"},   int'(d_tick),   e.tick);
`endif
    endtask

    task automatic advance_models();
        if (sh == S_HV + S_HF + S_HS + S_HB - 1) begin
            sh = 0;
            sv = (sv == S_VV + S_VF + S_VS + S_VB - 1) ? 0 : sv + 1;
        end else begin
            sh = sh + 1;
        end
        if (dh == D_HV + D_HF + D_HS + D_HB - 1) begin
            dh = 0;
            dv = (dv == D_VV + D_VF + D_VS + D_VB - 1) ? 0 : dv + 1;
        end else begin
            dh = dh + 1;
        end
    endtask

    task automatic run_cycles(input int n, input string pfx);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_25MHz);
            advance_models();
            push_expected(0);
            @(negedge clk_25MHz);
            compare_outputs(pfx);
        end
    endtask

    initial begin
        sh = 0; sv = 0; dh = 0; dv = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_25MHz);
        push_expected(1);
        compare_outputs("reset");

        reset_n = 1'b1;
        @(posedge clk_25MHz);
        advance_models();
        push_expected(0);
        @(negedge clk_25MHz);
        chk("first_edge_hcount", int'(s_hcount), 1);
        compare_outputs("release");

        // 2000 clocks: >3 small frames, 2.5 default lines
        run_cycles(1999, "run");
`ifdef VGA_FRAME_TICK_EN
        chk("small_tick_count", s_ticks, 2000 / 570);
`endif

        // walk the small instance to (25,9) then drop reset between edges
        for (int i = 0; i < 600 && !(sh == 25 && sv == 9); i++) run_cycles(1, "walk");
        chk("walk_reached_h", sh, 25);
        chk("walk_reached_v", sv, 9);
        #5;
        reset_n = 1'b0;
        #1;
        sh = 0; sv = 0; dh = 0; dv = 0;
        push_expected(1);
        compare_outputs("async_reset");
        @(negedge clk_25MHz);
        push_expected(1);
        compare_outputs("held_reset");

        reset_n = 1'b1;
        run_cycles(1, "restart");
        chk("restart_hcount", int'(s_hcount), 1);
        chk("restart_vcount", int'(s_vcount), 0);
        run_cycles(700, "post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
